// File: rtl/shift_wb_stage_pkg.sv
// Shared widths, shifter function codes and the writeback entry payload.
package shift_wb_stage_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned WB_SH_W   = $clog2(WB_DATA_W);

  typedef enum logic [2:0] {
    SH_LSL = 3'b000,
    SH_LSR = 3'b001,
    SH_ASL = 3'b010,
    SH_ASR = 3'b011,
    SH_ROL = 3'b100,
    SH_ROR = 3'b101
  } sh_ftn_e;

  typedef struct packed {
    logic [WB_DATA_W-1:0] result;
    logic [WB_ADDR_W-1:0] dest;
    logic                 z;
    logic                 n;
    logic                 c;
  } wb_entry_t;

endpackage

// File: rtl/shift_wb_stage_flag_gen.sv
// Combinational Z/N/C status flags for one shifter result.
module shift_flag_gen
  import shift_wb_stage_pkg::*;
#(
  parameter  int unsigned DATA_W = WB_DATA_W,
  localparam int unsigned SH_W   = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] operand,
  input  logic [SH_W-1:0]   sh,
  input  logic [2:0]        ftn,
  output logic              z_c,
  output logic              n_c,
  output logic              c_c
);

  logic [SH_W:0]   lsl_full;
  logic [SH_W-1:0] lsl_idx;
  logic [SH_W-1:0] lsr_idx;

  // Carry is the last bit shifted out, or the wrapped bit for rotates.
  always_comb begin
    lsl_full = (SH_W+1)'(DATA_W) - {1'b0, sh};
    lsl_idx  = lsl_full[SH_W-1:0];
    lsr_idx  = sh - SH_W'(1);
    z_c      = (result == '0);
    n_c      = result[DATA_W-1];
    c_c      = 1'b0;
    if (sh != '0) begin
      case (ftn)
        SH_LSL, SH_ASL: c_c = operand[lsl_idx];
        SH_LSR, SH_ASR: c_c = operand[lsr_idx];
        SH_ROL:         c_c = result[0];
        SH_ROR:         c_c = result[DATA_W-1];
        default:        c_c = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/shift_wb_stage.sv
// Shifter -> writeback stage: main register plus one skid entry, registered in_ready.
module shift_wb_stage
  import shift_wb_stage_pkg::*;
#(
  parameter  int unsigned DATA_W = WB_DATA_W,
  parameter  int unsigned ADDR_W = WB_ADDR_W,
  localparam int unsigned SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_operand,
  input  logic [SH_W-1:0]   in_sh,
  input  logic [2:0]        in_ftn,
  input  logic [ADDR_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [ADDR_W-1:0] out_dest,
  output logic              out_we,
  output logic              out_z,
  output logic              out_n,
  output logic              out_c
);

  wb_entry_t main_q, main_d;
  wb_entry_t skid_q, skid_d;
  wb_entry_t new_entry;
  logic      main_valid_q, main_valid_d;
  logic      skid_valid_q, skid_valid_d;
  logic      in_ready_q, in_ready_d;
  logic      out_we_q, out_we_d;
  logic      z_c, n_c, c_c;
  logic      accept, pop;

  shift_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
    .result  (in_result),
    .operand (in_operand),
    .sh      (in_sh),
    .ftn     (in_ftn),
    .z_c     (z_c),
    .n_c     (n_c),
    .c_c     (c_c)
  );

  // Skid is only ever filled while main is full, so main stays the older entry.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    accept       = in_valid & in_ready_q;
    pop          = main_valid_q & out_ready;
    new_entry    = '{result: in_result, dest: in_dest, z: z_c, n: n_c, c: c_c};

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = new_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end

    in_ready_d = !skid_valid_d;
    out_we_d   = main_valid_d && (main_d.dest != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_we_q     <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      out_we_q     <= out_we_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid_q;
  assign out_result = main_q.result;
  assign out_dest   = main_q.dest;
  assign out_we     = out_we_q;
  assign out_z      = main_q.z;
  assign out_n      = main_q.n;
  assign out_c      = main_q.c;

endmodule

// File: tb/tb_shift_wb_stage.sv
// Self-checking bench: queue-based reference model, directed flag/handshake cases, random run.
module tb_shift_wb_stage;
  import shift_wb_stage_pkg::*;

  logic        clk, rst_n, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_result, in_operand, out_result;
  logic [4:0]  in_sh, in_dest, out_dest;
  logic [2:0]  in_ftn;
  logic        out_we, out_z, out_n, out_c;

  int n_cmp = 0;
  int n_fail = 0;
  int pops_n = 0;
  bit chk_en = 0;
  wb_entry_t mq[$];

  shift_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_operand(in_operand), .in_sh(in_sh),
    .in_ftn(in_ftn), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest), .out_we(out_we),
    .out_z(out_z), .out_n(out_n), .out_c(out_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Carry from the shift definition: last bit out for shifts, wrapped bit for rotates.
  function automatic logic ref_carry(input logic [31:0] res, input logic [31:0] op,
                                     input int sh, input int ftn);
    if (sh == 0) return 1'b0;
    case (ftn)
      0, 2:    return 1'((op >> (32 - sh)) & 32'd1);
      1, 3:    return 1'((op >> (sh - 1)) & 32'd1);
      4:       return 1'(res & 32'd1);
      5:       return 1'(res >> 31);
      default: return 1'b0;
    endcase
  endfunction

  // Reference: a 2-deep FIFO; in_ready means fewer than two held.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      automatic bit acc = in_valid && (mq.size() < 2);
      automatic bit pp  = (mq.size() > 0) && out_ready;
      automatic wb_entry_t e;
      if (flush) begin
        mq.delete();
      end else begin
        if (pp) begin
          void'(mq.pop_front());
          pops_n++;
        end
        if (acc) begin
          e.result = in_result;
          e.dest   = in_dest;
          e.z      = (in_result == 32'd0);
          e.n      = in_result[31];
          e.c      = ref_carry(in_result, in_operand, int'(in_sh), int'(in_ftn));
          mq.push_back(e);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      if (mq.size() > 0) begin
        chk("out_result", out_result, mq[0].result);
        chk("out_dest", 32'(out_dest), 32'(mq[0].dest));
        chk("out_we", 32'(out_we), 32'(mq[0].dest != 5'd0));
        chk("out_znc", 32'({out_z, out_n, out_c}), 32'({mq[0].z, mq[0].n, mq[0].c}));
      end else begin
        chk("out_we_idle", 32'(out_we), 32'd0);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [31:0] op,
                       input logic [4:0] sh, input logic [2:0] ftn, input logic [4:0] dest);
    in_valid   = v;
    in_result  = res;
    in_operand = op;
    in_sh      = sh;
    in_ftn     = ftn;
    in_dest    = dest;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 3'd0, 5'd0);
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Logical shift left carry.
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0002, 32'h8000_0001, 5'd1, 3'b000, 5'd3);
    tick();
    drive(1'b0, 32'd0, 32'd0, 5'd0, 3'd0, 5'd0);
    chk("t2_valid_we", 32'({out_valid, out_we}), 32'b11);
    chk("t2_znc", 32'({out_z, out_n, out_c}), 32'b001);
    chk("t2_dest", 32'(out_dest), 32'd3);

    // Arithmetic right, then logical right to zero.
    drive(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 5'd31, 3'b011, 5'd7);
    tick();
    chk("t3a_znc", 32'({out_z, out_n, out_c}), 32'b010);
    drive(1'b1, 32'h0000_0000, 32'h0000_0001, 5'd1, 3'b001, 5'd8);
    tick();
    chk("t3b_znc", 32'({out_z, out_n, out_c}), 32'b101);

    // Zero destination, zero shift: valid but no write, no carry.
    drive(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 3'b101, 5'd0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 5'd0, 3'd0, 5'd0);
    chk("t6_valid_we", 32'({out_valid, out_we}), 32'b10);
    chk("t6_c", 32'(out_c), 32'd0);
    tick();

    // Stall with three results offered; drain in order.
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 32'd0, 5'd0, 3'd0, 5'd1);
    tick();
    drive(1'b1, 32'hBBBB_0002, 32'd0, 5'd0, 3'd0, 5'd2);
    tick();
    drive(1'b1, 32'hCCCC_0003, 32'd0, 5'd0, 3'd0, 5'd3);
    tick();
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    chk("t4_hold_A", out_result, 32'hAAAA_0001);
    out_ready = 1'b1;
    tick();
    chk("t4_B", out_result, 32'hBBBB_0002);
    tick();
    drive(1'b0, 32'd0, 32'd0, 5'd0, 3'd0, 5'd0);
    chk("t4_C", out_result, 32'hCCCC_0003);
    tick();
    chk("t4_drained", 32'(out_valid), 32'd0);

    // Flush with both entries full and a new input offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h1111_1111, 32'd0, 5'd0, 3'd0, 5'd4);
    tick();
    drive(1'b1, 32'h2222_2222, 32'd0, 5'd0, 3'd0, 5'd5);
    tick();
    drive(1'b1, 32'hDEAD_BEEF, 32'd0, 5'd0, 3'd0, 5'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 3'd0, 5'd0);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_we", 32'(out_we), 32'd0);
    tick();
    chk("t5_no_ghost", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream with the skid entry occupied.
    drive(1'b1, 32'h3333_3333, 32'd0, 5'd0, 3'd0, 5'd9);
    tick();
    drive(1'b1, 32'h4444_4444, 32'd0, 5'd0, 3'd0, 5'd10);
    tick();
    chk("t1_pre_skid_full", 32'(in_ready), 32'd0);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t1_out_valid", 32'(out_valid), 32'd0);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    chk("t1_outs", out_result | 32'(out_dest) | 32'({out_we, out_z, out_n, out_c}), 32'd0);
    drive(1'b0, 32'd0, 32'd0, 5'd0, 3'd0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Random valid/ready/flush run against the model.
    pops_n = 0;
    for (int cyc = 0; cyc < 60000 && pops_n < 10000; cyc++) begin
      @(posedge clk);
      #1;
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 255) == 0);
      in_result  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      in_operand = 32'($urandom);
      in_sh      = 5'($urandom_range(0, 31));
      in_ftn     = 3'($urandom_range(0, 7));
      in_dest    = 5'($urandom_range(0, 31));
    end
    flush = 1'b0; in_valid = 1'b0;
    chk("rand_items_reached", 32'(pops_n >= 10000), 32'd1);
    tick();
    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
